// File: rtl/apb_regs_slave_if.sv
// ---------------------------------------------------------------------------
// apb_regs_slave_if
// APB3 bus bundle between a requester (bridge side) and the register block.
//
// Signals:
//   psel     select, driven by the master
//   penable  access-phase marker, driven by the master
//   pwrite   1 = write, 0 = read, driven by the master
//   paddr    byte address, driven by the master
//   pwdata   write data, driven by the master
//   prdata   read data, driven by the completer
//   pready   transfer complete, driven by the completer
//   pslverr  error response, driven by the completer
// ---------------------------------------------------------------------------
interface apb_regs_slave_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [31:0]           pwdata;
    logic [31:0]           prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_regs_slave.sv
// ---------------------------------------------------------------------------
// apb_regs_slave
// APB3 completer exposing NUM_REGS read/write 32-bit control registers plus
// one read-only status word placed at the index right after them. Every
// access phase is stretched by WAIT_CYCLES pready-low cycles; unmapped
// accesses and writes to the status word answer with pslverr.
//
// Ports:
//   clk         clock, rising edge
//   rstn        asynchronous active-low reset
//   apb         APB3 bus (slave modport)
//   regs_o      flattened RW registers, reg i at [32*i+31:32*i]
//   wr_pulse_o  one-cycle strobe per register after a committed write
//   status_i    read-only status word
// ---------------------------------------------------------------------------
module apb_regs_slave #(
    parameter int          NUM_REGS    = 8,
    parameter int          ADDR_WIDTH  = 12,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] RESET_VAL   = 32'h0
) (
    input  logic                     clk,
    input  logic                     rstn,
    apb_regs_slave_if.slave          apb,
    output logic [32*NUM_REGS-1:0]   regs_o,
    output logic [NUM_REGS-1:0]      wr_pulse_o,
    input  logic [31:0]              status_i
);

    localparam int         IDX_W     = ADDR_WIDTH - 2;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    logic [1:0]       state;
    logic [3:0]       wait_cnt;
    logic [31:0]      regs [NUM_REGS];

    logic [IDX_W-1:0] idx;
    logic [31:0]      idx_ext;
    logic             is_reg;
    logic             is_status;
    logic             is_unmapped;
    logic             ack;
    logic             commit;
    logic [31:0]      rd_mux;

    // Word index; widened so comparisons against NUM_REGS are width-clean.
    assign idx         = apb.paddr[ADDR_WIDTH-1:2];
    assign idx_ext     = 32'(idx);
    assign is_reg      = idx_ext <  32'(NUM_REGS);
    assign is_status   = idx_ext == 32'(NUM_REGS);
    assign is_unmapped = idx_ext >  32'(NUM_REGS);

    // A completion is only signalled while the master still holds the
    // access phase; a dropped psel in ACK silently ends the transfer.
    assign ack         = (state == ST_ACK) && apb.psel && apb.penable;
    assign commit      = ack && apb.pwrite && is_reg;

    assign apb.pready  = ack;
    assign apb.pslverr = ack && (is_unmapped || (is_status && apb.pwrite));
    assign apb.prdata  = ack ? rd_mux : 32'h0;

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        rd_mux = 32'h0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx_ext == 32'(i)) rd_mux = regs[i];
        end
        if (is_status) rd_mux = status_i;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Only a genuine setup phase starts a transfer; a lone
                    // penable without the setup cycle is ignored.
                    if (apb.psel && !apb.penable) begin
                        wait_cnt <= WAIT_LOAD;
                        state    <= (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!apb.psel) begin
                        state    <= ST_IDLE;
                        wait_cnt <= 4'd0;
                    end else if (wait_cnt == 4'd1) begin
                        state    <= ST_ACK;
                        wait_cnt <= 4'd0;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_ACK:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the register file is built from flops, not RAM, so each entry is
    // reset explicitly to RESET_VAL.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
            wr_pulse_o <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                wr_pulse_o[i] <= commit && (idx_ext == 32'(i));
                if (commit && (idx_ext == 32'(i))) regs[i] <= apb.pwdata;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_o[32*g +: 32] = regs[g];
    end

endmodule

// File: tb/tb_apb_regs_slave.sv
// ---------------------------------------------------------------------------
// tb_apb_regs_slave
// Three register blocks with different wait-state counts share one APB
// driver; psel is routed to the current target only. The driver pushes the
// expected response of each transfer into a queue; a monitor pops it when
// the target raises pready and checks latency, response and register side
// effects one cycle later.
// ---------------------------------------------------------------------------
module tb_apb_regs_slave;

    localparam int N = 8;

    typedef struct {
        int           tgt;
        logic         is_read;
        logic [31:0]  rdata;
        logic         err;
        int           ack_cyc;
        logic [7:0]   pulse;
        logic [255:0] regs;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [11:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] status = '0;
    int          target = 0;
    int          cyc = 0;

    int checks = 0;
    int failures = 0;

    int          waits [3] = '{0, 3, 2};
    logic [31:0] rvals [3] = '{32'h0, 32'h0, 32'hA5A5_0F0F};
    logic [31:0] model [3][N];
    exp_t        sb_q [$];

    logic [255:0] regs0, regs1, regs2;
    logic [7:0]   pulse0, pulse1, pulse2;
    logic [2:0]   rdy, err;
    logic [31:0]  rd [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    apb_regs_slave_if #(.ADDR_WIDTH(12)) b0 ();
    apb_regs_slave_if #(.ADDR_WIDTH(12)) b1 ();
    apb_regs_slave_if #(.ADDR_WIDTH(12)) b2 ();

    assign b0.psel = psel && (target == 0);
    assign b1.psel = psel && (target == 1);
    assign b2.psel = psel && (target == 2);
    assign {b0.penable, b1.penable, b2.penable} = {3{penable}};
    assign {b0.pwrite,  b1.pwrite,  b2.pwrite}  = {3{pwrite}};
    assign {b0.paddr,   b1.paddr,   b2.paddr}   = {3{paddr}};
    assign {b0.pwdata,  b1.pwdata,  b2.pwdata}  = {3{pwdata}};
    assign rdy = {b2.pready,  b1.pready,  b0.pready};
    assign err = {b2.pslverr, b1.pslverr, b0.pslverr};
    assign rd[0] = b0.prdata;
    assign rd[1] = b1.prdata;
    assign rd[2] = b2.prdata;

    apb_regs_slave #(.NUM_REGS(N), .ADDR_WIDTH(12), .WAIT_CYCLES(0), .RESET_VAL(32'h0))
    dut0 (.clk(clk), .rstn(rstn), .apb(b0), .regs_o(regs0), .wr_pulse_o(pulse0), .status_i(status));
    apb_regs_slave #(.NUM_REGS(N), .ADDR_WIDTH(12), .WAIT_CYCLES(3), .RESET_VAL(32'h0))
    dut1 (.clk(clk), .rstn(rstn), .apb(b1), .regs_o(regs1), .wr_pulse_o(pulse1), .status_i(status));
    apb_regs_slave #(.NUM_REGS(N), .ADDR_WIDTH(12), .WAIT_CYCLES(2), .RESET_VAL(32'hA5A5_0F0F))
    dut2 (.clk(clk), .rstn(rstn), .apb(b2), .regs_o(regs2), .wr_pulse_o(pulse2), .status_i(status));

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [255:0] dut_regs(input int t);
        case (t)
            0:       return regs0;
            1:       return regs1;
            default: return regs2;
        endcase
    endfunction

    function automatic logic [7:0] dut_pulse(input int t);
        case (t)
            0:       return pulse0;
            1:       return pulse1;
            default: return pulse2;
        endcase
    endfunction

    function automatic logic [255:0] model_flat(input int t);
        logic [255:0] f;
        for (int i = 0; i < N; i++) f[32*i +: 32] = model[t][i];
        return f;
    endfunction

    task automatic model_reset();
        for (int t = 0; t < 3; t++)
            for (int i = 0; i < N; i++) model[t][i] = rvals[t];
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            psel = 1'b0;
            penable = 1'b0;
        end
    endtask

    // One complete transfer; returns at the negedge where pready was seen so
    // the next call can start its setup in the cycle right after ACK.
    task automatic xfer(input int t, input logic wr, input logic [11:0] addr,
                        input logic [31:0] data, input logic [31:0] stat);
        exp_t e;
        int   idx;
        int   n;
        @(posedge clk); #1;
        target = t;
        status = stat;
        psel = 1'b1;
        penable = 1'b0;
        pwrite = wr;
        paddr = addr;
        pwdata = data;
        idx = int'(addr[11:2]);
        e.tgt = t;
        e.is_read = !wr;
        e.ack_cyc = cyc + 1 + waits[t];
        e.pulse = '0;
        e.rdata = '0;
        e.err = 1'b0;
        if (wr) begin
            if (idx < N) begin
                model[t][idx] = data;
                e.pulse[idx] = 1'b1;
            end else begin
                e.err = 1'b1;
            end
        end else begin
            if (idx < N)       e.rdata = model[t][idx];
            else if (idx == N) e.rdata = stat;
            else               e.err = 1'b1;
        end
        e.regs = model_flat(t);
        sb_q.push_back(e);
        @(posedge clk); #1;
        penable = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (rdy[t]) break;
            n++;
            if (n > 40) begin
                check("pready_timeout", 256'(1'b0), 256'(1'b1));
                sb_q.delete();
                psel = 1'b0;
                penable = 1'b0;
                break;
            end
        end
    endtask

    // Monitor: pops an expectation whenever any block presents pready and
    // checks side effects on the following cycle.
    exp_t post_e;
    logic post_valid = 1'b0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (post_valid) begin
                check($sformatf("wr_pulse_t%0d", post_e.tgt), 256'(dut_pulse(post_e.tgt)), 256'(post_e.pulse));
                check($sformatf("regs_t%0d", post_e.tgt), dut_regs(post_e.tgt), post_e.regs);
                post_valid = 1'b0;
            end else if ((pulse0 | pulse1 | pulse2) != 8'h0) begin
                check("stray_pulse", 256'(pulse0 | pulse1 | pulse2), 256'(0));
            end
            if (rdy != 3'b000) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_pready", 256'(rdy), 256'(0));
                end else begin
                    e = sb_q.pop_front();
                    check("ready_owner", 256'(rdy), 256'(3'b001 << e.tgt));
                    check("ack_cycle", 256'(cyc), 256'(e.ack_cyc));
                    check("pslverr", 256'(err[e.tgt]), 256'(e.err));
                    if (e.is_read) check("prdata", 256'(rd[e.tgt]), 256'(e.rdata));
                    post_e = e;
                    post_valid = 1'b1;
                end
            end
        end
    end

    initial begin
        model_reset();

        // Reset state of all three blocks.
        #12;
        for (int t = 0; t < 3; t++) begin
            check($sformatf("rst_regs_t%0d", t), dut_regs(t), model_flat(t));
            check($sformatf("rst_pulse_t%0d", t), 256'(dut_pulse(t)), 256'(0));
            check($sformatf("rst_prdata_t%0d", t), 256'(rd[t]), 256'(0));
        end
        check("rst_ready_err", 256'({rdy, err}), 256'(0));
        @(posedge clk); #1;
        rstn = 1'b1;

        // Zero wait states: write then back-to-back read of idx 2.
        xfer(0, 1'b1, 12'h008, 32'hDEAD_BEEF, 32'h0);
        xfer(0, 1'b0, 12'h008, 32'h0, 32'h0);
        check("regs0_idx2", 256'(regs0[95:64]), 256'(32'hDEAD_BEEF));

        // Three wait states: read idx 0 after reset.
        idle(1);
        xfer(1, 1'b0, 12'h000, 32'h0, 32'h0);

        // Status word and unmapped addresses.
        idle(1);
        xfer(0, 1'b0, 12'h020, 32'h0, 32'h1234_5678);
        xfer(0, 1'b1, 12'h020, 32'hFFFF_FFFF, 32'h1234_5678);
        xfer(0, 1'b0, 12'h040, 32'h0, 32'h1234_5678);
        xfer(0, 1'b1, 12'h040, 32'h0BAD_F00D, 32'h1234_5678);

        // penable without a setup phase must not start a transfer.
        idle(1);
        @(posedge clk); #1;
        target = 0;
        psel = 1'b1;
        penable = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("no_setup_ready", 256'(rdy[0]), 256'(0));
        end
        idle(2);

        // psel dropped in the second access cycle of a write to idx 1.
        @(posedge clk); #1;
        target = 2;
        psel = 1'b1;
        penable = 1'b0;
        pwrite = 1'b1;
        paddr = 12'h004;
        pwdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0;
        penable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("abort_regs2", regs2, model_flat(2));
        xfer(2, 1'b1, 12'h004, 32'h1357_9BDF, 32'h0);
        xfer(2, 1'b0, 12'h004, 32'h0, 32'h0);

        // Reset asserted while a write sits in WAIT.
        idle(1);
        xfer(1, 1'b1, 12'h00C, 32'hCAFE_0001, 32'h0);
        @(posedge clk); #1;
        psel = 1'b1;
        penable = 1'b0;
        pwrite = 1'b1;
        paddr = 12'h010;
        pwdata = 32'h7777_7777;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        rstn = 1'b0;
        psel = 1'b0;
        penable = 1'b0;
        model_reset();
        #1;
        check("rst_mid_ready", 256'(rdy), 256'(0));
        for (int t = 0; t < 3; t++)
            check($sformatf("rst_mid_regs_t%0d", t), dut_regs(t), model_flat(t));
        @(posedge clk); #1;
        rstn = 1'b1;
        xfer(1, 1'b1, 12'h010, 32'h2468_ACE0, 32'h0);
        xfer(1, 1'b0, 12'h010, 32'h0, 32'h0);

        // Randomized traffic against the reference model.
        for (int t = 0; t < 3; t++) begin
            idle(1);
            for (int k = 0; k < 40; k++) begin
                logic [11:0] a;
                logic [9:0]  ix;
                ix = 10'($urandom_range(0, 11));
                a = {ix, 2'($urandom)};
                if ($urandom_range(0, 7) == 0) a = 12'($urandom);
                xfer(t, 1'($urandom), a, $urandom, $urandom);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end

        idle(3);
        check("scoreboard_empty", 256'(sb_q.size()), 256'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
